// File: rtl/snake_tick_ctrl.sv
`default_nettype none
// == snake_tick_ctrl: game tick divider with speed levels, pause, halt and overrun flag ==
// == Rev 1.0 ==
module snake_tick_ctrl #(
   parameter int CNT_W    = 24,
   parameter int BASE_DIV = 12500000,
   parameter int STEP_DIV = 1250000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       pause,
   input  logic       speed_up,
   input  logic       game_over,
   input  logic       tick_ack,
   output logic       tick_req,
   output logic [2:0] level,
   output logic       overrun,
   output logic [1:0] state
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      PAUSED = 2'd2,
      HALT   = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] BASE_C = CNT_W'(BASE_DIV);
   localparam logic [CNT_W-1:0] STEP_C = CNT_W'(STEP_DIV);
   localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] counter_q, counter_d;
   logic [CNT_W-1:0] div_active_q, div_active_d;
   logic [2:0]       level_q, level_d;
   logic             tick_req_q, tick_req_d;
   logic             overrun_q, overrun_d;
   logic             wrap;
   logic             active;

   function automatic logic [CNT_W-1:0] div_for(input logic [2:0] lvl);
      return BASE_C - STEP_C * CNT_W'(lvl);
   endfunction

   always_comb begin
      state_d      = state_q;
      counter_d    = counter_q;
      div_active_d = div_active_q;
      level_d      = level_q;
      tick_req_d   = tick_req_q;
      overrun_d    = overrun_q;
      active       = (state_q == RUN) || (state_q == PAUSED);
      wrap         = (state_q == RUN) && (counter_q == div_active_q - ONE_C);

      if (game_over && active) begin
         state_d    = HALT;
         tick_req_d = 1'b0;
      end else if (start) begin
         state_d      = RUN;
         counter_d    = '0;
         level_d      = 3'd0;
         div_active_d = BASE_C;
         tick_req_d   = 1'b0;
         overrun_d    = 1'b0;
      end else if (active) begin
         // The cycle that enters PAUSED still counts; PAUSED itself holds the counter.
         if (state_q == RUN) begin
            counter_d = wrap ? '0 : counter_q + ONE_C;
            if (pause) begin
               state_d = PAUSED;
            end
         end else if (!pause) begin
            state_d = RUN;
         end

         if (speed_up && (level_q != 3'd7)) begin
            level_d = level_q + 3'd1;
         end

         if (tick_ack) begin
            tick_req_d = 1'b0;
         end

         // A new divisor only takes effect on a period boundary.
         if (wrap) begin
            if (tick_req_q && !tick_ack) begin
               overrun_d = 1'b1;
            end
            tick_req_d   = 1'b1;
            div_active_d = div_for(level_d);
         end else if ((state_q == PAUSED) && !pause && (counter_q == '0)) begin
            div_active_d = div_for(level_d);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         counter_q    <= '0;
         div_active_q <= BASE_C;
         level_q      <= 3'd0;
         tick_req_q   <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         counter_q    <= counter_d;
         div_active_q <= div_active_d;
         level_q      <= level_d;
         tick_req_q   <= tick_req_d;
         overrun_q    <= overrun_d;
      end
   end

   assign tick_req = tick_req_q;
   assign level    = level_q;
   assign overrun  = overrun_q;
   assign state    = state_q;

endmodule
`default_nettype wire

// File: tb/tb_snake_tick_ctrl.sv
`default_nettype none
// == tb_snake_tick_ctrl: scoreboard bench for snake_tick_ctrl (BASE_DIV=10, STEP_DIV=1) ==
// == Rev 1.0 ==
module tb_snake_tick_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start, pause, speed_up, game_over;
   logic       ack_auto, ack_man, auto_en;
   logic       tick_ack;
   logic       tick_req;
   logic [2:0] level;
   logic       overrun;
   logic [1:0] state;

   int cyc = 0;
   int n_tests = 0;
   int n_fail = 0;
   int s;

   typedef struct {
      int cyc;
      int lvl;
   } exp_t;
   exp_t sb[$];

   assign tick_ack = ack_auto | ack_man;

   snake_tick_ctrl #(.CNT_W(8), .BASE_DIV(10), .STEP_DIV(1)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .pause     (pause),
      .speed_up  (speed_up),
      .game_over (game_over),
      .tick_ack  (tick_ack),
      .tick_req  (tick_req),
      .level     (level),
      .overrun   (overrun),
      .state     (state)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int exp_v);
      n_tests++;
      if (act != exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cyc %0d)", nm, act, exp_v, cyc);
      end
   endtask

   task automatic tick_clk(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push(input int c, input int l);
      exp_t e;
      e.cyc = c;
      e.lvl = l;
      sb.push_back(e);
   endtask

   task automatic do_start();
      start = 1'b1;
      tick_clk(1);
      start = 1'b0;
      s = cyc;
   endtask

   task automatic do_halt();
      game_over = 1'b1;
      tick_clk(1);
      game_over = 1'b0;
      chk("halt_state", int'(state), 3);
      chk("halt_req", int'(tick_req), 0);
   endtask

   // Monitor: each rising tick_req is matched against the oldest expected tick.
   initial begin
      logic prev;
      exp_t e;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (tick_req && !prev) begin
            if (sb.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_tick: got tick at cyc %0d expected none", cyc);
            end else begin
               e = sb.pop_front();
               chk("tick_cycle", cyc, e.cyc);
               chk("tick_level", int'(level), e.lvl);
            end
         end
         prev = tick_req;
      end
   end

   // Acknowledge one cycle after each request when enabled.
   initial begin
      ack_auto = 1'b0;
      forever begin
         @(negedge clk);
         ack_auto = auto_en && tick_req && !ack_auto;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0; start = 1'b0; pause = 1'b0; speed_up = 1'b0;
      game_over = 1'b0; ack_man = 1'b0; auto_en = 1'b1;
      tick_clk(3);
      chk("rst_state", int'(state), 0);
      chk("rst_req", int'(tick_req), 0);
      chk("rst_level", int'(level), 0);
      chk("rst_overrun", int'(overrun), 0);
      rst_n = 1'b1;
      tick_clk(2);

      // Basic ticking with prompt acknowledge
      do_start();
      push(s + 10, 0); push(s + 20, 0); push(s + 30, 0);
      tick_clk(32);
      chk("a_overrun", int'(overrun), 0);
      chk("a_state", int'(state), 1);
      do_halt();

      // Speed-up mid-period: old period finishes, then period 9
      do_start();
      push(s + 10, 0); push(s + 20, 1); push(s + 29, 1); push(s + 38, 1);
      tick_clk(13);
      speed_up = 1'b1;
      tick_clk(1);
      speed_up = 1'b0;
      chk("b_level", int'(level), 1);
      tick_clk(25);
      do_halt();
      game_over = 1'b1;
      tick_clk(1);
      game_over = 1'b0;
      chk("halt_ignore_go", int'(state), 3);

      // Overrun without acknowledge
      auto_en = 1'b0;
      do_start();
      push(s + 10, 0);
      tick_clk(19);
      chk("c_ov_before", int'(overrun), 0);
      chk("c_req_before", int'(tick_req), 1);
      tick_clk(1);
      chk("c_ov_after", int'(overrun), 1);
      chk("c_req_after", int'(tick_req), 1);

      // Restart from RUN clears everything; then ack coinciding with a wrap
      do_start();
      chk("rs_overrun", int'(overrun), 0);
      chk("rs_req", int'(tick_req), 0);
      chk("rs_level", int'(level), 0);
      chk("rs_state", int'(state), 1);
      push(s + 10, 0); push(s + 30, 0);
      tick_clk(19);
      ack_man = 1'b1;
      tick_clk(1);
      ack_man = 1'b0;
      chk("c2_req_hold", int'(tick_req), 1);
      chk("c2_ov_clear", int'(overrun), 0);
      ack_man = 1'b1;
      tick_clk(1);
      ack_man = 1'b0;
      chk("c2_req_acked", int'(tick_req), 0);
      tick_clk(18);
      chk("c2_ov_before", int'(overrun), 0);
      tick_clk(1);
      chk("c2_ov_after", int'(overrun), 1);
      do_halt();
      auto_en = 1'b1;

      // Pause for ten cycles delays the first tick by ten cycles
      do_start();
      push(s + 20, 0);
      tick_clk(4);
      pause = 1'b1;
      tick_clk(2);
      chk("d_paused", int'(state), 2);
      tick_clk(8);
      pause = 1'b0;
      tick_clk(1);
      chk("d_resumed", int'(state), 1);
      tick_clk(6);
      do_halt();

      // game_over outranks start in the same cycle
      do_start();
      tick_clk(4);
      game_over = 1'b1;
      start = 1'b1;
      tick_clk(1);
      game_over = 1'b0;
      start = 1'b0;
      chk("e_state", int'(state), 3);
      chk("e_req", int'(tick_req), 0);
      do_start();
      push(s + 10, 0);
      tick_clk(11);
      chk("e_level", int'(level), 0);

      // Asynchronous reset mid-period
      do_start();
      tick_clk(6);
      rst_n = 1'b0;
      #1;
      chk("f_rst_state", int'(state), 0);
      chk("f_rst_level", int'(level), 0);
      chk("f_rst_req", int'(tick_req), 0);
      tick_clk(1);
      rst_n = 1'b1;
      tick_clk(6);
      chk("f_no_tick", int'(tick_req), 0);
      chk("f_idle", int'(state), 0);
      speed_up = 1'b1;
      tick_clk(1);
      speed_up = 1'b0;
      chk("f_idle_speed", int'(level), 0);

      // Level saturation and divisor 3 at level 7
      do_start();
      push(s + 10, 5); push(s + 15, 7); push(s + 18, 7);
      push(s + 21, 7); push(s + 24, 7);
      for (int i = 0; i < 8; i++) begin
         speed_up = 1'b1;
         tick_clk(1);
         speed_up = 1'b0;
         chk("f_level_step", int'(level), (i + 1 > 7) ? 7 : i + 1);
         tick_clk(1);
      end
      tick_clk(9);
      do_halt();

      tick_clk(5);
      chk("sb_empty", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/snake_tick_ctrl.md
SNAKE_TICK_CTRL -- requirements
Module: snake_tick_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 24, width of the tick counter.
REQ-002 SHALL have parameter BASE_DIV, default 12500000, clk cycles per game tick at level 0.
REQ-003 SHALL have parameter STEP_DIV, default 1250000, divisor reduction per speed level; BASE_DIV - 7*STEP_DIV SHALL be >= 2.
REQ-004 SHALL have port clk, input, 1, clock.
REQ-005 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have port start, input, 1, single-cycle pulse that begins or restarts a game.
REQ-007 SHALL have port pause, input, 1, level; high freezes ticking.
REQ-008 SHALL have port speed_up, input, 1, single-cycle pulse that requests the next speed level.
REQ-009 SHALL have port game_over, input, 1, single-cycle pulse that stops ticking.
REQ-010 SHALL have port tick_ack, input, 1, game logic has consumed the pending tick.
REQ-011 SHALL have port tick_req, output, 1, registered, high while a tick is pending.
REQ-012 SHALL have port level, output, 3, current speed level 0..7.
REQ-013 SHALL have port overrun, output, 1, sticky; a tick was due while the previous tick was unacknowledged.
REQ-014 SHALL have port state, output, 2, FSM state: IDLE=0, RUN=1, PAUSED=2, HALT=3.

Function
REQ-015 Divisor for level L SHALL be BASE_DIV - L*STEP_DIV, held in div_active.
REQ-016 In IDLE: counter=0, level=0, tick_req=0; start SHALL move to RUN with counter=0 and div_active=BASE_DIV.
REQ-017 In RUN: counter SHALL increment each cycle; when counter==div_active-1 it SHALL wrap to 0 and tick_req SHALL be 1 the following cycle.
REQ-018 First tick_req after start SHALL rise exactly BASE_DIV cycles after the cycle start is sampled.
REQ-019 tick_req SHALL stay high until tick_ack is sampled high; tick_ack while tick_req=0 SHALL be ignored.
REQ-020 If a wrap occurs while tick_req=1 and tick_ack=0, overrun SHALL set and tick_req SHALL stay 1; no tick is queued.
REQ-021 If tick_ack and a wrap occur in the same cycle, tick_req SHALL stay 1 and overrun SHALL NOT set.
REQ-022 speed_up in RUN or PAUSED SHALL increment level, saturating at 7; div_active SHALL update only at the next wrap (or at resume if counter=0), never mid-period.
REQ-023 pause=1 in RUN SHALL move to PAUSED the next cycle with counter frozen; pause=0 SHALL return to RUN and resume counting from the frozen value.
REQ-024 In PAUSED, tick_req SHALL hold its value and tick_ack SHALL still clear it.
REQ-025 game_over in RUN or PAUSED SHALL move to HALT, clear tick_req and freeze level; in IDLE or HALT it SHALL be ignored.
REQ-026 start in HALT or RUN or PAUSED SHALL restart: state RUN, counter 0, level 0, div_active=BASE_DIV, tick_req 0, overrun 0.
REQ-027 Same-cycle priority SHALL be: game_over > start > pause > speed_up.
REQ-028 speed_up and start in IDLE or HALT SHALL follow REQ-026/REQ-027; speed_up alone there SHALL be ignored.

Reset
REQ-029 rst_n low SHALL asynchronously force state=IDLE, counter=0, level=0, div_active=BASE_DIV, tick_req=0, overrun=0, including mid-period or mid-pause.
REQ-030 After rst_n deasserts, no tick_req SHALL occur until start is sampled.

Verification (BASE_DIV=10, STEP_DIV=1)
REQ-031 start at cycle 0, tick_ack 1 cycle after each req -> tick_req rises at cycles 10, 20, 30; overrun stays 0.
REQ-032 speed_up pulse at cycle 14 -> level=1 at cycle 15; ticks at 20 (old period), then 29, 38.
REQ-033 No tick_ack after first tick -> tick_req high from cycle 10, overrun=1 at cycle 20, tick_req remains single-level high.
REQ-034 pause high cycles 5..14 (10 cycles) -> tick at cycle 20 instead of 10; counter frozen during pause.
REQ-035 game_over and start in same cycle during RUN -> HALT, tick_req=0; then start -> next tick exactly 10 cycles later, level=0.
REQ-036 rst_n pulsed low at cycle 7 during RUN -> state=IDLE immediately, no tick_req at cycle 10; 7 speed_up pulses then 1 more -> level saturates at 7, divisor 3.
